// File: rtl/shaft_odometer.sv
// shaft_odometer: wheel encoder conditioning, pulse counting and
// handshaked "move N pulses" sequencing with stall detection.
module shaft_odometer #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int STALL_CYCLES    = 25_000_000,
    parameter int COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shaftPulseL,
    input  logic               shaftPulseR,
    input  logic               cmdValid,
    input  logic [COUNT_W-1:0] cmdTarget,
    output logic               cmdReady,
    input  logic               abort,
    output logic [COUNT_W-1:0] countL,
    output logic [COUNT_W-1:0] countR,
    output logic               moveBusy,
    output logic               moveDone,
    output logic               stall
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STALL_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STALL_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_tick;

    assign w_raw = {shaftPulseR, shaftPulseL};

    // Index 0 is the left wheel, index 1 the right wheel.
    for (genvar g = 0; g < 2; g++) begin : g_cond
        logic [1:0]      r_sync;
        logic            r_filt;
        logic            r_filtDly;
        logic            r_tick;
        logic [DB_W-1:0] r_dbCnt;
        logic            w_differ;

        assign w_differ = r_sync[1] ^ r_filt;

        // Two-flop synchronizer for the asynchronous raw pulse.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[0], w_raw[g]};
            end
        end

        // Filtered level follows only after DEBOUNCE_CYCLES of disagreement.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_filt  <= 1'b0;
                r_dbCnt <= '0;
            end else if (!w_differ) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
                r_filt  <= r_sync[1];
                r_dbCnt <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
        end

        // One-cycle tick on each filtered rising edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_filtDly <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_filtDly <= r_filt;
                r_tick    <= r_filt & ~r_filtDly;
            end
        end

        assign w_tick[g] = r_tick;
    end

    state_t             r_state;
    state_t             w_nextState;
    logic [COUNT_W-1:0] r_target;
    logic [COUNT_W-1:0] r_countL;
    logic [COUNT_W-1:0] r_countR;
    logic [ST_W-1:0]    r_stallCnt;
    logic               r_stall;
    logic               w_accept;
    logic               w_reached;
    logic               w_stallHit;
    logic               w_inRun;

    assign w_inRun    = (r_state == S_RUN);
    assign w_accept   = (r_state == S_IDLE) & cmdValid;
    assign w_reached  = (r_countL >= r_target) && (r_countR >= r_target);
    assign w_stallHit = (r_stallCnt == ST_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: abort beats completion, completion beats stall.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cmdValid) begin
                    if (cmdTarget == '0) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_nextState = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_nextState = S_IDLE;
                end else if (w_reached) begin
                    w_nextState = S_DONE;
                end else if (w_stallHit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        cmdReady = 1'b0;
        moveBusy = 1'b0;
        moveDone = 1'b0;
        unique case (r_state)
            S_IDLE:  cmdReady = 1'b1;
            S_RUN:   moveBusy = 1'b1;
            S_DONE:  moveDone = 1'b1;
            default: cmdReady = 1'b0;
        endcase
    end

    // Target latch, captured on command acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
        end else if (w_accept) begin
            r_target <= cmdTarget;
        end
    end

    // Saturating pulse counters; only ticks seen while running count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_countL <= '0;
            r_countR <= '0;
        end else if (w_accept) begin
            r_countL <= '0;
            r_countR <= '0;
        end else if (w_inRun) begin
            if (w_tick[0] && (r_countL != CNT_MAX)) begin
                r_countL <= r_countL + COUNT_W'(1);
            end
            if (w_tick[1] && (r_countR != CNT_MAX)) begin
                r_countR <= r_countR + COUNT_W'(1);
            end
        end
    end

    // Stall timer: counts running cycles since the last tick on either wheel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_accept) begin
            r_stallCnt <= '0;
        end else if (w_inRun) begin
            if (|w_tick) begin
                r_stallCnt <= '0;
            end else begin
                r_stallCnt <= r_stallCnt + ST_W'(1);
            end
        end
    end

    // Sticky stall flag, set only when the timeout actually ends the move.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= 1'b0;
        end else if (w_accept) begin
            r_stall <= 1'b0;
        end else if (w_inRun && !abort && !w_reached && w_stallHit) begin
            r_stall <= 1'b1;
        end
    end

    assign countL = r_countL;
    assign countR = r_countR;
    assign stall  = r_stall;

endmodule

// File: doc/shaft_odometer.md
Name: shaft_odometer

Overview:
- Upstream sensing stage for the drive state machine.
- Conditions the left/right wheel shaft-encoder pulses and counts them.
- Runs handshaked "move N pulses" commands: the drive logic issues a target, drives the H-bridge, then waits for moveDone instead of a fixed-time junction counter.
- Flags a stalled wheel so the drive logic can abort a turn or straight run.

Parameters:
DEBOUNCE_CYCLES, 50_000, consecutive stable clk cycles required before a filtered encoder level changes (1 ms at 50 MHz).
STALL_CYCLES, 25_000_000, clk cycles in RUN with no tick on either wheel before stall is declared (0.5 s).
COUNT_W, 16, width of pulse counters and cmdTarget.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
shaftPulseL  in  1  raw left encoder pulse, asynchronous
shaftPulseR  in  1  raw right encoder pulse, asynchronous
cmdValid  in  1  move command present
cmdTarget  in  COUNT_W  pulses each wheel must travel
cmdReady  out  1  block can accept a command (high only in IDLE)
abort  in  1  cancel active move
countL  out  COUNT_W  left pulses since last accepted command
countR  out  COUNT_W  right pulses since last accepted command
moveBusy  out  1  high in RUN
moveDone  out  1  one-cycle pulse on normal or stall completion
stall  out  1  sticky; last move ended by stall timeout

Behaviour:
- Reset values (rst high at a clk edge):
  - state = IDLE; cmdReady = 1; countL = countR = 0; moveBusy = moveDone = stall = 0.
  - Filtered levels = 0; debounce and stall counters = 0.
  - Reset mid-RUN discards the move; no moveDone is produced.
- Input conditioning, per wheel, independent:
  - 2-flop synchronizer, then debouncer.
  - Debouncer holds a count of consecutive cycles in which the synchronized value differs from the filtered level.
  - The count resets to 0 whenever the two agree.
  - When the count reaches DEBOUNCE_CYCLES, the filtered level takes the new value and the count clears.
  - A filtered 0->1 transition produces a one-cycle tick on the next cycle.
  - Glitches shorter than DEBOUNCE_CYCLES produce no tick.
- State machine, states IDLE, RUN, DONE:
  - IDLE:
    - cmdReady = 1; abort is ignored.
    - On cmdValid & cmdReady: latch cmdTarget; clear countL, countR and stall.
    - If the target is 0, go to DONE; otherwise go to RUN.
    - Ticks arriving in IDLE are not counted.
  - RUN:
    - moveBusy = 1; cmdReady = 0.
    - Each tick increments its counter the cycle after the tick; counters saturate at all-ones, no wrap.
    - Ticks on L and R in the same cycle both count.
    - Stall counter increments every cycle and clears on any tick.
    - Exit priority, evaluated each cycle:
      1. abort -> IDLE, no moveDone, stall unchanged (0).
      2. countL >= target and countR >= target -> DONE.
      3. stall counter == STALL_CYCLES - 1 -> set stall = 1, go to DONE.
    - abort in the same cycle as target reached or stall: abort wins.
  - DONE:
    - moveDone = 1 for exactly this one cycle.
    - Next state is IDLE; a command can be accepted on the following cycle.
- Latency:
  - Target completion: the last qualifying count update is at cycle N, DONE is at N+1, so moveDone is high at N+1.
  - Raw edge to count: 2 sync cycles + DEBOUNCE_CYCLES + 1 tick cycle + 1 count cycle.
- Outputs:
  - countL and countR hold their final values after DONE or abort until the next command is accepted.
  - stall remains high until the next command is accepted or rst.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, STALL_CYCLES=100, COUNT_W=8.

1. Basic move: cmdTarget=3; apply 3 clean pulses per wheel (10 cycles high, 10 low) -> countL=countR=3, moveDone pulses once, stall=0, cmdReady=1 one cycle after moveDone.
2. Debounce: 2-cycle glitches on shaftPulseL plus 5 clean pulses, target=5 -> countL=5, no extra counts; moveDone only after the 5th right pulse.
3. Stall: target=10; 2 pulses per wheel, then silence -> moveDone and stall=1 exactly 100 cycles after the last tick; counts hold at 2.
4. Abort race: target=1; assert abort in the cycle the final count lands -> state IDLE, no moveDone, stall=0.
5. Zero target / ignored ticks: cmdTarget=0 -> moveDone on the cycle after accept with counts 0; pulses while in IDLE leave counts unchanged.
6. Reset mid-RUN and saturation:
   - rst asserted during RUN with countL=7 -> all outputs at reset values next cycle.
   - Separately, target=255 with 300 left pulses -> countL saturates at 255.
